// File: rtl/ysyx_22050019_lsu_ctrl.sv
// Load/store unit controller. It accepts one memory instruction at a time and
// runs a req/gnt/rvalid transaction on the data port. Store data and strobes
// are aligned to the addressed lane, and load data is extended.
// The write-back triple is zero unless it is valid, so MEM/WB can OR it in.
module ysyx_22050019_lsu_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic        clk,
    input  logic        rst_n,          // active-high despite the name
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [63:0] pc_i,
    input  logic        mem_ren_i,
    input  logic        mem_wen_i,
    input  logic [2:0]  mem_op_i,
    input  logic [63:0] addr_i,
    input  logic [63:0] wdata_i,
    input  logic [4:0]  rd_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [63:0] dmem_addr_o,
    output logic [63:0] dmem_wdata_o,
    output logic [7:0]  dmem_wstrb_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [63:0] dmem_rdata_i,
    output logic        done_o,
    output logic [63:0] pc_o,
    output logic        reg_we_lsu_o,
    output logic [4:0]  reg_waddr_lsu_o,
    output logic [63:0] reg_wdata_lsu_o,
    output logic        err_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [63:0]   pc_q, addr_q, wdata_q, ldata_q;
    logic          ren_q, wen_q, err_q;
    logic [2:0]    op_q;
    logic [4:0]    rd_q;
    logic [7:0]    strb_q, strb_base;
    logic          accept, misaligned, tmo, capture;
    logic [63:0]   lane, ld_ext;

    assign accept  = valid_i && (state_q == IDLE);
    assign cnt_inc = cnt_q + 1'b1;

    // Alignment check and strobe pattern for the incoming instruction
    always_comb begin
        misaligned = 1'b0;
        strb_base  = 8'hFF;
        case (mem_op_i[1:0])
            2'b00: strb_base = 8'h01;
            2'b01: begin strb_base = 8'h03; misaligned = addr_i[0]; end
            2'b10: begin strb_base = 8'h0F; misaligned = (addr_i[1:0] != 2'b00); end
            default: misaligned = (addr_i[2:0] != 3'b000);
        endcase
    end

    // Select the addressed lane of the read data and extend it
    always_comb begin
        lane = dmem_rdata_i >> {addr_q[2:0], 3'b000};
        case (op_q)
            3'b000:  ld_ext = {{56{lane[7]}},  lane[7:0]};
            3'b001:  ld_ext = {{48{lane[15]}}, lane[15:0]};
            3'b010:  ld_ext = {{32{lane[31]}}, lane[31:0]};
            3'b100:  ld_ext = {56'd0, lane[7:0]};
            3'b101:  ld_ext = {48'd0, lane[15:0]};
            3'b110:  ld_ext = {32'd0, lane[31:0]};
            default: ld_ext = lane;
        endcase
    end

    // Next-state logic; the wait counter restarts on each entry to REQ or WAIT
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo     = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                cnt_d = '0;
                if (!mem_ren_i && !mem_wen_i) state_d = RESP;
                else if (misaligned)          state_d = RESP;
                else                          state_d = REQ;
            end
            REQ: begin
                // An rvalid in the gnt cycle is illegal on this bus and is ignored
                if (dmem_gnt_i) begin
                    state_d = wen_q ? RESP : WAIT;
                    cnt_d   = '0;
                end else if (cnt_inc == TW'(TIMEOUT)) begin
                    state_d = RESP;
                    tmo     = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAIT: begin
                if (dmem_rvalid_i) begin
                    state_d = RESP;
                    capture = 1'b1;
                end else if (cnt_inc == TW'(TIMEOUT)) begin
                    state_d = RESP;
                    tmo     = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and timeout counter
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Instruction latch, pre-aligned store data, error flag and load result
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            pc_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            ldata_q <= '0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
            op_q    <= '0;
            rd_q    <= '0;
            strb_q  <= '0;
        end else begin
            if (accept) begin
                pc_q    <= pc_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i << {addr_i[2:0], 3'b000};
                strb_q  <= strb_base << addr_i[2:0];
                ren_q   <= mem_ren_i;
                wen_q   <= mem_wen_i;
                op_q    <= mem_op_i;
                rd_q    <= rd_i;
                err_q   <= (mem_ren_i || mem_wen_i) && misaligned;
                ldata_q <= '0;
            end
            if (tmo)     err_q   <= 1'b1;
            if (capture) ldata_q <= ld_ext;
        end
    end

    // Outputs come from registered state only; bus fields are zero unless requesting
    always_comb begin
        ready_o         = (state_q == IDLE);
        dmem_req_o      = (state_q == REQ);
        dmem_we_o       = dmem_req_o && wen_q;
        dmem_addr_o     = dmem_req_o ? {addr_q[63:3], 3'b000} : 64'd0;
        dmem_wdata_o    = dmem_we_o ? wdata_q : 64'd0;
        dmem_wstrb_o    = dmem_we_o ? strb_q : 8'd0;
        done_o          = (state_q == RESP);
        pc_o            = done_o ? pc_q : 64'd0;
        err_o           = done_o && err_q;
        reg_we_lsu_o    = done_o && ren_q && !err_q && (rd_q != 5'd0);
        reg_waddr_lsu_o = reg_we_lsu_o ? rd_q : 5'd0;
        reg_wdata_lsu_o = reg_we_lsu_o ? ldata_q : 64'd0;
    end

endmodule

// File: tb/tb_ysyx_22050019_lsu_ctrl.sv
// Directed bench for the LSU controller: a vector table run against a
// zero-wait memory model, plus sequences for a stalled grant, a timeout and
// a reset in mid-transaction.
module tb_ysyx_22050019_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        valid_i = 1'b0, ready_o;
    logic [63:0] pc_i = '0;
    logic        mem_ren_i = 1'b0, mem_wen_i = 1'b0;
    logic [2:0]  mem_op_i = '0;
    logic [63:0] addr_i = '0, wdata_i = '0;
    logic [4:0]  rd_i = '0;
    logic        dmem_req_o, dmem_we_o;
    logic [63:0] dmem_addr_o, dmem_wdata_o;
    logic [7:0]  dmem_wstrb_o;
    logic        dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
    logic [63:0] dmem_rdata_i = '0;
    logic        done_o, reg_we_lsu_o, err_o;
    logic [63:0] pc_o, reg_wdata_lsu_o;
    logic [4:0]  reg_waddr_lsu_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_22050019_lsu_ctrl #(.TIMEOUT(8), .TW(8)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .pc_i(pc_i), .mem_ren_i(mem_ren_i), .mem_wen_i(mem_wen_i),
        .mem_op_i(mem_op_i), .addr_i(addr_i), .wdata_i(wdata_i), .rd_i(rd_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i(dmem_rdata_i), .done_o(done_o), .pc_o(pc_o),
        .reg_we_lsu_o(reg_we_lsu_o), .reg_waddr_lsu_o(reg_waddr_lsu_o),
        .reg_wdata_lsu_o(reg_wdata_lsu_o), .err_o(err_o)
    );

    typedef struct {
        string       name;
        logic        ren, wen;
        logic [2:0]  op;
        logic [63:0] addr, wdata, rdata;
        logic [4:0]  rd;
        logic        exp_req;
        logic [63:0] exp_dwdata;
        logic [7:0]  exp_strb;
        int          lat;
        logic        exp_err, exp_we;
        logic [4:0]  exp_waddr;
        logic [63:0] exp_rwdata;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic ren, input logic wen,
                                input logic [2:0] op, input logic [63:0] addr,
                                input logic [63:0] wdata, input logic [63:0] rdata,
                                input logic [4:0] rd, input logic exp_req,
                                input logic [63:0] exp_dwdata, input logic [7:0] exp_strb,
                                input int lat, input logic exp_err, input logic exp_we,
                                input logic [4:0] exp_waddr, input logic [63:0] exp_rwdata);
        vec_t v;
        v.name = name; v.ren = ren; v.wen = wen; v.op = op; v.addr = addr;
        v.wdata = wdata; v.rdata = rdata; v.rd = rd; v.exp_req = exp_req;
        v.exp_dwdata = exp_dwdata; v.exp_strb = exp_strb; v.lat = lat;
        v.exp_err = exp_err; v.exp_we = exp_we; v.exp_waddr = exp_waddr;
        v.exp_rwdata = exp_rwdata;
        return v;
    endfunction

    task automatic drive(input vec_t v, input logic [63:0] pc);
        valid_i = 1'b1; pc_i = pc; mem_ren_i = v.ren; mem_wen_i = v.wen;
        mem_op_i = v.op; addr_i = v.addr; wdata_i = v.wdata; rd_i = v.rd;
        dmem_rdata_i = v.rdata;
    endtask

    // One transaction against a memory that grants at once and answers next cycle
    task automatic run(input vec_t v, input logic [63:0] pc);
        int   cyc = 0;
        logic seen_req = 1'b0, seen_done = 1'b0, pend = 1'b0;
        @(negedge clk);
        chk({v.name, ".ready"}, ready_o, 1'b1);
        drive(v, pc);
        while (!seen_done && cyc < 30) begin
            @(negedge clk);
            cyc++;
            valid_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
            if (done_o) begin
                seen_done = 1'b1;
                chk({v.name, ".err"},   err_o, v.exp_err);
                chk({v.name, ".we"},    reg_we_lsu_o, v.exp_we);
                chk({v.name, ".waddr"}, reg_waddr_lsu_o, v.exp_waddr);
                chk({v.name, ".wdata"}, reg_wdata_lsu_o, v.exp_rwdata);
                chk({v.name, ".pc"},    pc_o, pc);
            end else if (dmem_req_o) begin
                if (!seen_req) begin
                    chk({v.name, ".daddr"}, dmem_addr_o, {v.addr[63:3], 3'b000});
                    chk({v.name, ".dwe"},   dmem_we_o, v.wen);
                    if (v.wen) begin
                        chk({v.name, ".dwdata"}, dmem_wdata_o, v.exp_dwdata);
                        chk({v.name, ".wstrb"},  dmem_wstrb_o, v.exp_strb);
                    end
                end
                seen_req = 1'b1;
                dmem_gnt_i = 1'b1;
                pend = v.ren;
            end else if (pend) begin
                dmem_rvalid_i = 1'b1;
                pend = 1'b0;
            end
        end
        chk({v.name, ".done_seen"}, seen_done, 1'b1);
        chk({v.name, ".latency"}, cyc, v.lat);
        chk({v.name, ".req_seen"}, seen_req, v.exp_req);
        @(negedge clk);
        chk({v.name, ".done_1cyc"}, done_o, 1'b0);
        chk({v.name, ".ready_after"}, ready_o, 1'b1);
    endtask

    initial begin
        int   cyc;
        logic seen;
        vecs[0]  = mk("lb",    1,0,3'b000,64'h8000_0003,0,64'h0000_0000_8000_0000,5, 1,0,0,3,0,1,5, 64'hFFFF_FFFF_FFFF_FF80);
        vecs[1]  = mk("lhu",   1,0,3'b101,64'h8000_0006,0,64'hBEEF_0000_0000_0000,7, 1,0,0,3,0,1,7, 64'h0000_0000_0000_BEEF);
        vecs[2]  = mk("lh",    1,0,3'b001,64'h8000_0006,0,64'hBEEF_0000_0000_0000,3, 1,0,0,3,0,1,3, 64'hFFFF_FFFF_FFFF_BEEF);
        vecs[3]  = mk("lw",    1,0,3'b010,64'h8000_0004,0,64'h8765_4321_0000_0000,10,1,0,0,3,0,1,10,64'hFFFF_FFFF_8765_4321);
        vecs[4]  = mk("lwu",   1,0,3'b110,64'h8000_0004,0,64'h8765_4321_0000_0000,11,1,0,0,3,0,1,11,64'h0000_0000_8765_4321);
        vecs[5]  = mk("ld",    1,0,3'b011,64'h8000_0008,0,64'h0123_4567_89AB_CDEF,12,1,0,0,3,0,1,12,64'h0123_4567_89AB_CDEF);
        vecs[6]  = mk("lbu",   1,0,3'b100,64'h8000_0001,0,64'h0000_0000_0000_F000,13,1,0,0,3,0,1,13,64'h0000_0000_0000_00F0);
        vecs[7]  = mk("lb_x0", 1,0,3'b000,64'h8000_0000,0,64'h0000_0000_0000_00FF,0, 1,0,0,3,0,0,0, 64'h0);
        vecs[8]  = mk("ld_mis",1,0,3'b011,64'h8000_0004,0,64'h0123_4567_89AB_CDEF,9, 0,0,0,1,1,0,0, 64'h0);
        vecs[9]  = mk("lh_mis",1,0,3'b001,64'h8000_0001,0,64'h0,                  9, 0,0,0,1,1,0,0, 64'h0);
        vecs[10] = mk("sb",    0,1,3'b000,64'h8000_0005,64'hAB,0,0,1,64'h0000_AB00_0000_0000,8'h20,2,0,0,0,64'h0);
        vecs[11] = mk("sh",    0,1,3'b001,64'h8000_0002,64'hBEEF,0,0,1,64'h0000_0000_BEEF_0000,8'h0C,2,0,0,0,64'h0);
        vecs[12] = mk("sd",    0,1,3'b011,64'h8000_0010,64'h1122_3344_5566_7788,0,0,1,64'h1122_3344_5566_7788,8'hFF,2,0,0,0,64'h0);
        vecs[13] = mk("nop",   0,0,3'b000,64'h8000_0000,0,64'hFF,4,0,0,0,1,0,0,0,64'h0);
        vecs[14] = mk("sw_mis",0,1,3'b010,64'h8000_0002,64'h1234_5678,0,0,0,0,0,1,1,0,0,64'h0);

        // Reset state
        #12;
        chk("rst.ready", ready_o, 1'b1);
        chk("rst.req",   dmem_req_o, 1'b0);
        chk("rst.done",  done_o, 1'b0);
        chk("rst.err",   err_o, 1'b0);
        chk("rst.we",    reg_we_lsu_o, 1'b0);
        chk("rst.pc",    pc_o, 64'h0);
        @(negedge clk);
        rst_n = 1'b0;

        for (int i = 0; i < 15; i++) run(vecs[i], 64'h8000_1000 + 64'(i * 4));

        // sw with the grant held off for four cycles
        @(negedge clk);
        valid_i = 1'b1; pc_i = 64'h8000_2000; mem_ren_i = 1'b0; mem_wen_i = 1'b1;
        mem_op_i = 3'b010; addr_i = 64'h8000_0004; wdata_i = 64'h1234_5678; rd_i = 5'd9;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            valid_i = 1'b0;
            chk("sw_stall.req",    dmem_req_o, 1'b1);
            chk("sw_stall.addr",   dmem_addr_o, 64'h8000_0000);
            chk("sw_stall.wdata",  dmem_wdata_o, 64'h1234_5678_0000_0000);
            chk("sw_stall.wstrb",  dmem_wstrb_o, 8'hF0);
            dmem_gnt_i = (i == 4);
        end
        @(negedge clk);
        dmem_gnt_i = 1'b0;
        chk("sw_stall.done", done_o, 1'b1);
        chk("sw_stall.we",   reg_we_lsu_o, 1'b0);
        chk("sw_stall.err",  err_o, 1'b0);
        chk("sw_stall.pc",   pc_o, 64'h8000_2000);

        // Load whose rvalid never comes: eight cycles in WAIT, then an error
        @(negedge clk);
        valid_i = 1'b1; pc_i = 64'h8000_3000; mem_ren_i = 1'b1; mem_wen_i = 1'b0;
        mem_op_i = 3'b011; addr_i = 64'h8000_0000; rd_i = 5'd6;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            valid_i = 1'b0;
            dmem_gnt_i = dmem_req_o;
            if (done_o) seen = 1'b1;
        end
        dmem_gnt_i = 1'b0;
        chk("tmo.done_seen", seen, 1'b1);
        chk("tmo.latency",   cyc, 10);
        chk("tmo.err",       err_o, 1'b1);
        chk("tmo.we",        reg_we_lsu_o, 1'b0);
        chk("tmo.wdata",     reg_wdata_lsu_o, 64'h0);
        @(negedge clk);
        dmem_rvalid_i = 1'b1; dmem_gnt_i = 1'b1;
        @(negedge clk);
        dmem_rvalid_i = 1'b0; dmem_gnt_i = 1'b0;
        chk("tmo.late_done", done_o, 1'b0);
        chk("tmo.late_req",  dmem_req_o, 1'b0);
        chk("tmo.ready",     ready_o, 1'b1);

        // Reset while waiting for rvalid
        @(negedge clk);
        valid_i = 1'b1; pc_i = 64'h8000_4000; mem_ren_i = 1'b1; mem_wen_i = 1'b0;
        mem_op_i = 3'b011; addr_i = 64'h8000_0000; rd_i = 5'd4;
        @(negedge clk);
        valid_i = 1'b0;
        chk("rstw.req", dmem_req_o, 1'b1);
        dmem_gnt_i = 1'b1;
        @(negedge clk);
        dmem_gnt_i = 1'b0;
        chk("rstw.in_wait", ready_o, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("rstw.ready", ready_o, 1'b1);
        chk("rstw.req0",  dmem_req_o, 1'b0);
        @(negedge clk);
        chk("rstw.done0", done_o, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstw.done1", done_o, 1'b0);
        run(vecs[5], 64'h8000_5000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22050019_lsu_ctrl.md
Name: ysyx_22050019_lsu_ctrl

Overview:
Load/store unit stage directly upstream of the MEM/WB merge. It accepts one memory instruction at a time from the EX stage and runs a request/grant/response transaction on the data-memory port. It aligns store data and byte strobes, and sign/zero-extends load data. It presents the load result as the LSU write-back triple (we, waddr, wdata) consumed by MEM/WB, which ORs it with the EXU triple.

Parameters:
TIMEOUT, 255, number of cycles to wait for grant or rvalid before aborting with an error.
TW, 8, width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
clk  in  1  clock.
rst_n  in  1  reset. Asynchronous, active-high; the port name is kept for consistency with the other stages.
valid_i  in  1  EX stage presents an instruction.
ready_o  out  1  LSU can accept (state IDLE).
pc_i  in  64  instruction PC.
mem_ren_i  in  1  load.
mem_wen_i  in  1  store; mem_ren_i and mem_wen_i are never both 1.
mem_op_i  in  3  RV64 funct3: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
addr_i  in  64  effective byte address.
wdata_i  in  64  store data, LSB-justified.
rd_i  in  5  load destination register.
dmem_req_o  out  1  bus request.
dmem_we_o  out  1  1 = write.
dmem_addr_o  out  64  addr_i with bits [2:0] cleared.
dmem_wdata_o  out  64  store data shifted to lane addr_i[2:0]*8.
dmem_wstrb_o  out  8  byte strobes.
dmem_gnt_i  in  1  request accepted.
dmem_rvalid_i  in  1  read data valid.
dmem_rdata_i  in  64  aligned 8-byte read data.
done_o  out  1  one-cycle completion pulse to MEM/WB.
pc_o  out  64  PC of the completed instruction.
reg_we_lsu_o  out  1  load write-back enable.
reg_waddr_lsu_o  out  5  load destination register.
reg_wdata_lsu_o  out  64  extended load data.
err_o  out  1  one-cycle pulse on misalignment or timeout.

Behaviour:
- Reset (asynchronous): state = IDLE, timeout counter = 0, and all outputs = 0 except ready_o = 1.
- States and transitions:
  - IDLE: on valid_i & ready_o, latch all inputs.
    - If neither ren nor wen: go to RESP; completes with reg_we = 0.
    - If misaligned (h with addr[0] != 0, w with addr[1:0] != 0, d with addr[2:0] != 0): go to RESP with err.
    - Otherwise go to REQ.
  - REQ: dmem_req_o = 1; address, data and strobes held stable until dmem_gnt_i.
    - On gnt with a store: go to RESP.
    - On gnt with a load: go to WAIT.
  - WAIT: on dmem_rvalid_i, capture and extend the selected lane; go to RESP. An rvalid arriving in the same cycle as gnt is not legal on this bus and is ignored in REQ.
  - RESP: done_o = 1 for exactly one cycle, along with pc_o, reg_*, err_o; then go to IDLE.
- Strobes: b → 0x01 << off; h → 0x03 << off; w → 0x0F << off; d → 0xFF, where off = addr[2:0].
- Load extension: signed ops replicate the MSB of the selected byte/half/word to bit 63; unsigned ops zero-fill.
- reg_we_lsu_o = 1 only for a load completing without error.
- reg_waddr_lsu_o and reg_wdata_lsu_o must be 0 whenever reg_we_lsu_o = 0, because MEM/WB ORs them with the EXU fields.
- rd = x0: a load still completes, but reg_we_lsu_o = 0 and waddr/wdata = 0.
- Timeout: the counter resets on every entry to REQ/WAIT and increments each cycle spent in REQ or WAIT. When it reaches TIMEOUT, drop dmem_req_o, go to RESP with err_o = 1 and reg_we = 0. A late rvalid or gnt seen in IDLE is ignored.
- Latency with zero-wait memory:
  - Store: accept → REQ (gnt same cycle) → RESP, so done_o 2 cycles after acceptance.
  - Load: done_o 3 cycles after acceptance (rvalid the cycle after gnt).
- valid_i while not ready: the instruction is not consumed; EX must hold it.
- Reset asserted mid-transaction: return to IDLE immediately and drop dmem_req_o; no done_o is produced.

Test Plan:
- lb from addr 0x80000003 with rdata 0x0000_0000_8000_0000 (byte 3 = 0x80), rd = 5 → done_o after 3 cycles; reg_we = 1, waddr = 5, wdata = 0xFFFF_FFFF_FFFF_FF80.
- lhu from addr 0x80000006 with rdata 0xBEEF_0000_0000_0000, rd = 7 → wdata = 0x0000_0000_0000_BEEF.
- sw of data 0x1234_5678 to addr 0x80000004, gnt held low 4 cycles → req stays high with addr 0x80000000, wdata 0x1234_5678_0000_0000 and wstrb 0xF0 unchanged; done_o one cycle after gnt; reg_we = 0.
- ld from addr 0x80000004 → no dmem_req_o; done_o with err_o = 1, reg_we = 0, waddr = 0, wdata = 0.
- Load with rvalid never asserted and TIMEOUT = 8 → err_o + done_o after 8 cycles in WAIT; a later rvalid in IDLE causes no done_o.
- Reset pulse while in WAIT → ready_o = 1 and dmem_req_o = 0 immediately; a following ld completes normally.
